// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready on the way in,
// a one-cycle out_valid pulse (qualified by err) on the way out.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic               valid;
    logic               ready;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [2:0]         sel;
    logic [2*WIDTH-1:0] result;
    logic               out_valid;
    logic               err;

    modport master (
        output valid, op1, op2, sel,
        input  ready, result, out_valid, err
    );

    modport slave (
        input  valid, op1, op2, sel,
        output ready, result, out_valid, err
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle logic/add/shift, one-bit-per-clock MUL and DIV.
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise DIV reports err.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] SelAnd = 3'd0;
    localparam logic [2:0] SelAdd = 3'd1;
    localparam logic [2:0] SelSub = 3'd2;
    localparam logic [2:0] SelMul = 3'd3;
    localparam logic [2:0] SelDiv = 3'd4;
    localparam logic [2:0] SelOr  = 3'd5;
    localparam logic [2:0] SelShl = 3'd6;
    localparam logic [2:0] SelXor = 3'd7;

    localparam logic [DW-1:0]    ShlLimit = DW'(DW);
    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    result_q, result_d;
    logic             err_q, err_d;

    logic [DW-1:0]    op1z, op2z, fast_res, mul_acc, step_acc;
    logic             fast_err, iterative, shift_ops;

    assign op1z    = DW'(bus.op1);
    assign op2z    = DW'(bus.op2);
    assign mul_acc = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef SEQ_ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // acc holds {partial remainder, dividend shifting into quotient}; divisor sits in mplier.
    assign trial     = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign ge        = trial >= {1'b0, mplier_q};
    assign diff      = trial[WIDTH-1:0] - mplier_q;
    assign step_acc  = is_div_q ? {(ge ? diff : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge}
                                : mul_acc;
    assign shift_ops = !is_div_q;
`else
    assign step_acc  = mul_acc;
    assign shift_ops = 1'b1;
`endif

    always_comb begin
        fast_res  = '0;
        fast_err  = 1'b0;
        iterative = 1'b0;
        unique case (bus.sel)
            SelAnd: fast_res = op1z & op2z;
            SelAdd: fast_res = op1z + op2z;
            SelSub: fast_res = op1z - op2z;
            SelMul: iterative = 1'b1;
            SelDiv: begin
`ifdef SEQ_ALU_DIV_EN
                if (bus.op2 == '0) begin
                    fast_res = {bus.op1, {WIDTH{1'b1}}};
                    fast_err = 1'b1;
                end else begin
                    iterative = 1'b1;
                end
`else
                fast_err = 1'b1;
`endif
            end
            SelOr:  fast_res = op1z | op2z;
            SelShl: fast_res = (op2z >= ShlLimit) ? '0 : op1z << op2z;
            SelXor: fast_res = op1z ^ op2z;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef SEQ_ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    mcand_d  = op1z;
                    mplier_d = bus.op2;
                    acc_d    = (bus.sel == SelDiv) ? op1z : '0;
                    cnt_d    = '0;
                    err_d    = fast_err;
`ifdef SEQ_ALU_DIV_EN
                    is_div_d = (bus.sel == SelDiv);
`endif
                    if (iterative) begin
                        state_d = StBusy;
                    end else begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end
                end
            end
            StBusy: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (shift_ops) begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == LastCnt) begin
                    result_d = step_acc;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): latency, result, err, handshake and reset abort.
// Expectations follow SEQ_ALU_DIV_EN as defined for the build.
module tb_seq_alu;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, then count falling edges until out_valid (1 = first edge after accept).
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_err, input bit hold);
        int lat;
        int ready_hi;
        @(negedge clk);
        check_eq({tag, " ready_before"}, 64'(bus.ready), 64'd1);
        bus.valid = 1'b1;
        bus.sel   = sel;
        bus.op1   = a;
        bus.op2   = b;
        @(negedge clk);
        bus.valid = hold;
        bus.sel   = 3'd1;
        bus.op1   = 16'h1357;
        bus.op2   = 16'h2468;
        lat      = 1;
        ready_hi = bus.ready ? 1 : 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.ready) ready_hi++;
        end
        bus.valid = 1'b0;
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, 64'(bus.result), 64'(exp_res));
        check_eq({tag, " err"}, 64'(bus.err), 64'(exp_err));
        check_eq({tag, " ready_low"}, 64'(ready_hi), 64'd0);
        @(negedge clk);
        check_eq({tag, " pulse_end"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, " result_hold"}, 64'(bus.result), 64'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.sel   = 3'd0;
        bus.op1   = '0;
        bus.op2   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst ready", 64'(bus.ready), 64'd1);
        check_eq("rst out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst err", 64'(bus.err), 64'd0);
        check_eq("rst result", 64'(bus.result), 64'd0);
        rst = 1'b0;

        run_op("add", 3'd1, 16'hFFFF, 16'h0001, 1, 32'h0001_0000, 1'b0, 1'b0);
        run_op("sub", 3'd2, 16'd1, 16'd2, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("shl40", 3'd6, 16'd1, 16'd40, 1, 32'h0, 1'b0, 1'b0);
        run_op("shl31", 3'd6, 16'd1, 16'd31, 1, 32'h8000_0000, 1'b0, 1'b0);
        run_op("shl4", 3'd6, 16'h8003, 16'd4, 1, 32'h0008_0030, 1'b0, 1'b0);
        run_op("xor", 3'd7, 16'hF0F0, 16'h0FF0, 1, 32'h0000_FF00, 1'b0, 1'b0);
        run_op("and", 3'd0, 16'hF0F0, 16'h0FF0, 1, 32'h0000_00F0, 1'b0, 1'b0);
        run_op("or", 3'd5, 16'hF0F0, 16'h0FF0, 1, 32'h0000_FFF0, 1'b0, 1'b0);
        run_op("mul_max", 3'd3, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 1'b0, 1'b0);
        run_op("mul_hold", 3'd3, 16'd3, 16'd5, 17, 32'd15, 1'b0, 1'b1);
        run_op("mul_sh", 3'd3, 16'h1234, 16'h0010, 17, 32'h0001_2340, 1'b0, 1'b0);
`ifdef SEQ_ALU_DIV_EN
        run_op("div", 3'd4, 16'd100, 16'd7, 17, 32'h0002_000E, 1'b0, 1'b0);
        run_op("div0", 3'd4, 16'd5, 16'd0, 1, 32'h0005_FFFF, 1'b1, 1'b0);
`else
        run_op("div", 3'd4, 16'd100, 16'd7, 1, 32'h0, 1'b1, 1'b0);
        run_op("div0", 3'd4, 16'd5, 16'd0, 1, 32'h0, 1'b1, 1'b0);
`endif
        run_op("add_clr", 3'd1, 16'd2, 16'd3, 1, 32'd5, 1'b0, 1'b0);

        // Abort a MUL with reset at N+8 after accept.
        @(negedge clk);
        bus.valid = 1'b1;
        bus.sel   = 3'd3;
        bus.op1   = 16'h00FF;
        bus.op2   = 16'h00FF;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("abort busy", 64'(bus.ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort ready", 64'(bus.ready), 64'd1);
        check_eq("abort result", 64'(bus.result), 64'd0);
        check_eq("abort out_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b0;
        begin
            int pulses = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.out_valid) pulses++;
            end
            check_eq("abort no_pulse", 64'(pulses), 64'd0);
        end
        run_op("add_post", 3'd1, 16'h1234, 16'h4321, 1, 32'h0000_5555, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
